// File: rtl/axi4_lite_master_pkg.sv
// Shared AXI4-Lite definitions: response codes, command/response records and master FSM encoding.
// Build option AXI4_LITE_MST_TIMEOUT_EN enables the master's transaction watchdog.
package axi4_lite_master_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

  // Record layout for 32-bit sequencer-side command/response ports.
  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } axi_lite_cmd_t;

  typedef struct packed {
    logic        write;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } axi_lite_rsp_t;

  typedef logic [2:0] mst_state_t;

  localparam mst_state_t ST_IDLE         = 3'd0;
  localparam mst_state_t ST_WR_ADDR_DATA = 3'd1;
  localparam mst_state_t ST_WR_RESP      = 3'd2;
  localparam mst_state_t ST_RD_ADDR      = 3'd3;
  localparam mst_state_t ST_RD_DATA      = 3'd4;
  localparam mst_state_t ST_RSP          = 3'd5;

endpackage

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite initiator: command port in, AW/W/B or AR/R on the bus, response port out.
// Build option AXI4_LITE_MST_TIMEOUT_EN adds a per-phase watchdog and the sticky timeout_err output.
module axi4_lite_master
  import axi4_lite_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  localparam int STRB_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
`ifdef AXI4_LITE_MST_TIMEOUT_EN
  output logic                  timeout_err,
`endif
  output logic                  awvalid,
  input  logic                  awready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [2:0]            awprot,
  output logic                  wvalid,
  input  logic                  wready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [STRB_WIDTH-1:0] wstrb,
  input  logic                  bvalid,
  output logic                  bready,
  input  logic [1:0]            bresp,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [2:0]            arprot,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp
);

  mst_state_t            state_q, state_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;

  logic cmd_fire, aw_fire, w_fire, b_fire, ar_fire, r_fire, rsp_fire;

  assign cmd_ready = (state_q == ST_IDLE);
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign aw_fire   = awvalid_q & awready;
  assign w_fire    = wvalid_q & wready;
  assign b_fire    = bready_q & bvalid;
  assign ar_fire   = arvalid_q & arready;
  assign r_fire    = rready_q & rvalid;
  assign rsp_fire  = rsp_valid_q & rsp_ready;

`ifdef AXI4_LITE_MST_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_err_q, timeout_err_d;
  logic             tmo_waiting, tmo_handshake, tmo_hit;

  assign tmo_waiting   = (state_q == ST_WR_ADDR_DATA) || (state_q == ST_WR_RESP) ||
                         (state_q == ST_RD_ADDR) || (state_q == ST_RD_DATA);
  assign tmo_handshake = aw_fire | w_fire | b_fire | ar_fire | r_fire;
  assign tmo_hit       = tmo_waiting && !tmo_handshake &&
                         (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          addr_d = cmd_addr;
          if (cmd_write) begin
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WR_ADDR_DATA;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_RD_ADDR;
          end
        end
      end
      ST_WR_ADDR_DATA: begin
        // AW and W retire independently; the phase ends once neither is still pending.
        if (aw_fire) awvalid_d = 1'b0;
        if (w_fire)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        if (b_fire) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = bresp;
          state_d     = ST_RSP;
        end
      end
      ST_RD_ADDR: begin
        if (ar_fire) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (r_fire) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = rdata;
          rsp_resp_d  = rresp;
          state_d     = ST_RSP;
        end
      end
      ST_RSP: begin
        if (rsp_fire) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef AXI4_LITE_MST_TIMEOUT_EN
    // Abandon the bus transaction; with bready/rready low a late B/R beat is never taken.
    if (tmo_hit) begin
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      bready_d    = 1'b0;
      arvalid_d   = 1'b0;
      rready_d    = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_write_d = (state_q == ST_WR_ADDR_DATA) || (state_q == ST_WR_RESP);
      rsp_rdata_d = DATA_WIDTH'(32'hDEADBEEF);
      rsp_resp_d  = RESP_SLVERR;
      state_d     = ST_RSP;
    end

    timeout_err_d = timeout_err_q | tmo_hit;
    if (!tmo_waiting || tmo_handshake || (state_d != state_q)) tmo_cnt_d = '0;
    else                                                       tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

`ifdef AXI4_LITE_MST_TIMEOUT_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`endif

  assign awvalid   = awvalid_q;
  assign awaddr    = addr_q;
  assign awprot    = 3'b000;
  assign wvalid    = wvalid_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign bready    = bready_q;
  assign arvalid   = arvalid_q;
  assign araddr    = addr_q;
  assign arprot    = 3'b000;
  assign rready    = rready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;

endmodule

// File: doc/axi4_lite_master.md
Name: axi4_lite_master

Overview:
- Single-outstanding AXI4-Lite initiator.
- Converts a simple valid/ready command port (one read or write per command) into AXI4-Lite AW/W/B or AR/R transactions.
- Returns each result on a valid/ready response port.
- Sits between CPU-side/test-sequencer logic and `axi4_lite_slave` register blocks; it is the initiating end of the same bus.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data width; STRB_WIDTH = DATA_WIDTH/8 (localparam).
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles; used only when the optional feature is compiled in.

Ports:
- aclk  in  1  bus clock; all logic on its rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data; ignored for reads.
- cmd_wstrb  in  STRB_WIDTH  write strobes; ignored for reads.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  result consumed.
- rsp_write  out  1  echoes cmd_write of the completed command.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  BRESP/RRESP as received.
- awvalid/awready/awaddr/awprot, wvalid/wready/wdata/wstrb, bvalid/bready/bresp, arvalid/arready/araddr/arprot, rvalid/rready/rdata/rresp: standard AXI4-Lite master-side directions and widths. awprot and arprot are tied to 3'b000.

Behaviour:
- Interface: one clock (aclk); reset is asynchronous and active-low (aresetn).
- Reset values:
  - all AXI valids, bready, rready = 0
  - rsp_valid = 0, rsp_rdata = 0, rsp_resp = 0, rsp_write = 0
  - addresses, data and strobes = 0
  - FSM state = IDLE
- Every AXI output is registered. No combinational path from any AXI input to any AXI output.
- cmd_ready = (state == IDLE). Command fields are captured on the accepting edge.
- FSM states and transitions:
  - IDLE: on cmd fire, go to WR_ADDR_DATA (write) or RD_ADDR (read).
  - WR_ADDR_DATA:
    - awvalid and wvalid are asserted in the same cycle, on the cycle after acceptance.
    - awvalid drops on the cycle after aw fire; wvalid drops on the cycle after w fire. These are tracked independently (aw_done, w_done), so AW-first, W-first and simultaneous acceptance are all legal.
    - Once both have fired, go to WR_RESP.
    - awaddr, wdata and wstrb stay stable while their valid is high.
  - WR_RESP: bready = 1. On b fire: capture bresp, set rsp_write = 1 and rsp_rdata = 0, go to RSP.
  - RD_ADDR: arvalid = 1 and held until ar fire, then go to RD_DATA.
  - RD_DATA: rready = 1. On r fire: capture rdata and rresp, set rsp_write = 0, go to RSP.
  - RSP: rsp_valid = 1 with stable fields. On rsp fire, go to IDLE; rsp_valid drops the next cycle.
- Valid signals never depend on the corresponding ready (AXI rule). No valid deasserts before its handshake.
- Minimum latency, with a zero-wait slave and rsp_ready held high:
  - write: cmd fire to rsp_valid = 3 cycles
  - read: cmd fire to rsp_valid = 3 cycles
  - rsp to next cmd_ready: 1 cycle
- bready and rready are 0 outside WR_RESP and RD_DATA respectively.
- rsp_resp is passed through unchanged, including SLVERR (2'b10) and DECERR.
- Reset asserted mid-transaction: all outputs return to their reset values immediately (asynchronously). In-flight command and response are discarded.

Optional Feature:
- Macro: AXI4_LITE_MST_TIMEOUT_EN.
- When defined:
  - A counter runs in WR_ADDR_DATA, WR_RESP, RD_ADDR and RD_DATA.
  - It clears on each state entry and on any handshake.
  - On reaching TIMEOUT_CYCLES: all AXI valids and readies drop, rsp_resp = RESP_SLVERR, rsp_rdata = 32'hDEADBEEF, go to RSP.
  - Sticky output `timeout_err` (1-bit) is set; it clears only on reset.
  - Late B/R beats are never accepted.
- When undefined: no counter, no timeout_err port; the FSM waits indefinitely.

Decomposition:
- axi_pkg (shared):
  - RESP_OKAY/RESP_EXOKAY/RESP_SLVERR/RESP_DECERR constants
  - axi_lite_cmd_t and axi_lite_rsp_t structs
  - master state enum
  - default TIMEOUT_CYCLES
- No sub-module required. The FSM and datapath fit in one module.

Test Plan:
- Write cmd addr 0x18, data 0xA5A55A5A, strb 4'hF, then read 0x18 → write rsp_resp=0; read rsp_rdata=0xA5A55A5A, rsp_resp=0.
- Slave awready delayed 5 cycles, wready immediate (and the reverse) → wvalid drops after its fire; awvalid held stable 5 cycles; exactly one B; rsp_resp=0.
- Read 0x40 → rsp_resp=2'b10, rsp_rdata=0xDEADBEEF; next command accepted 1 cycle after rsp fire.
- rsp_ready held low 10 cycles after a read of 0x1C → rsp_valid and fields stable for 10 cycles; cmd_ready stays 0.
- aresetn pulsed low while awvalid=1 → awvalid, wvalid and rsp_valid = 0 asynchronously; cmd_ready=1 after release.
- (AXI4_LITE_MST_TIMEOUT_EN, TIMEOUT_CYCLES=16) bvalid never asserted → rsp_resp=2'b10 at cycle 16; timeout_err=1 until reset.
